laser_centroid: RTL and testbench
=================================

LASER_CENTROID -- requirements
Module: laser_centroid

Interface
REQ-001 Parameter H_RES, default 320, meaning pixels per line.
REQ-002 Parameter V_RES, default 240, meaning lines per frame.
REQ-003 Parameter BRIGHT_TH, default 4'd12, meaning a pixel is bright when din[15:12] > BRIGHT_TH.
REQ-004 Parameter MIN_PIX, default 17'd4, meaning the minimum bright-pixel count for a valid centroid.
REQ-005 Port pclk, input, 1, the single clock; all logic SHALL be on its rising edge.
REQ-006 Port rst_n, input, 1, asynchronous active-low reset.
REQ-007 Port vsync, input, 1, camera frame sync; high between frames.
REQ-008 Port we, input, 1, pixel-valid strobe from the capture stage.
REQ-009 Port din, input, 16, RGB565 pixel; valid when we=1.
REQ-010 Port avg_X, output, 17, centroid column, 0..H_RES-1.
REQ-011 Port avg_Y, output, 17, centroid row, 0..V_RES-1.
REQ-012 Port disappear, output, 1, high when the last completed frame had fewer than MIN_PIX bright pixels.
REQ-013 Port avg_valid, output, 1, one-cycle pulse when avg_X, avg_Y and disappear update.

Function
REQ-014 The block SHALL keep column counter x (0..H_RES-1) and row counter y, both cleared while vsync=1.
- Each we=1 SHALL advance x.
- x SHALL wrap from H_RES-1 to 0 and increment y.
REQ-015 Pixels with we=1 and y >= V_RES SHALL be ignored; the counters SHALL saturate.
REQ-016 In state ACCUM, each we=1 bright pixel SHALL add:
- x to sum_x (25 bits)
- y to sum_y (25 bits)
- 1 to cnt (17 bits)
REQ-017 A vsync rising edge, detected with a registered vsync, SHALL latch sum_x, sum_y and cnt, clear the accumulators, and move ACCUM -> CHECK.
REQ-018 In CHECK, the next state SHALL be chosen as follows:
- cnt < MIN_PIX: set disappear=1, hold avg_X/avg_Y, pulse avg_valid, return to ACCUM.
- otherwise: go to DIV_X.
REQ-019 DIV_X SHALL compute sum_x/cnt with a restoring divider, 1 quotient bit per cycle, exactly 25 cycles; the quotient is truncated.
REQ-020 DIV_Y SHALL compute sum_y/cnt the same way, exactly 25 cycles.
REQ-021 After DIV_Y, state DONE SHALL apply the following in one cycle, then return to ACCUM:
- load avg_X and avg_Y
- clear disappear
- pulse avg_valid
REQ-022 Latency from the vsync rising edge to avg_valid SHALL be 53 cycles for a valid frame and 3 cycles for a disappear frame.
REQ-023 A vsync rising edge that arrives while not in ACCUM SHALL be ignored; that frame's result is discarded.
REQ-024 Bright pixels arriving outside ACCUM SHALL NOT be accumulated.
REQ-025 avg_X and avg_Y SHALL change only in DONE.
REQ-026 avg_valid SHALL never be high for two consecutive cycles.

Reset
REQ-027 rst_n=0 SHALL asynchronously force the following; rst_n deassertion SHALL take effect on the next pclk edge:
- state=ACCUM
- x, y, sum_x, sum_y, cnt and divider registers = 0
- avg_X=0, avg_Y=0
- disappear=1
- avg_valid=0
REQ-028 A reset during DIV_X or DIV_Y SHALL abort the division with no avg_valid pulse.

Configuration
REQ-029 Macro CENTROID_PIXCNT_EN compiles in an extra output port pix_count, 17 bits, meaning the latched cnt.
- With the macro: pix_count SHALL be loaded on every avg_valid pulse and reset to 0.
- Without the macro: the port SHALL be absent, and no other behaviour changes.

Verification
REQ-030 A frame with a 3x3 bright block centred at (100,50) -> avg_valid 53 cycles after vsync rises, avg_X=100, avg_Y=50, disappear=0.
REQ-031 A frame with 3 bright pixels and MIN_PIX=4 -> avg_valid 3 cycles after vsync rises, disappear=1, avg_X/avg_Y unchanged from the prior frame.
REQ-032 Bright pixels at (0,0) and (319,239) -> avg_X=159, avg_Y=119, checking truncation and wrap.
REQ-033 A second vsync pulse injected 10 cycles after the first -> ignored; a single avg_valid; the result matches the first frame.
REQ-034 rst_n pulsed low during DIV_X -> no avg_valid; outputs at reset values; the next full frame computes correctly.
REQ-035 A frame with all 76800 pixels bright -> avg_X=159, avg_Y=119, with no accumulator overflow.

Source files
------------

// File: rtl/laser_centroid.sv
// Laser-spot centroid tracker.
// Accumulates the column/row sums of bright pixels over a frame. On each vsync
// rising edge it divides those sums by the bright-pixel count to report the
// spot centre, or flags the spot as missing when too few pixels were bright.
// Optional feature macro: CENTROID_PIXCNT_EN adds the pix_count output.
module laser_centroid #(
  parameter int unsigned H_RES     = 320,
  parameter int unsigned V_RES     = 240,
  parameter logic [3:0]  BRIGHT_TH = 4'd12,
  parameter logic [16:0] MIN_PIX   = 17'd4
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        vsync,
  input  logic        we,
  input  logic [15:0] din,
  output logic [16:0] avg_X,
  output logic [16:0] avg_Y,
  output logic        disappear,
  output logic        avg_valid
`ifdef CENTROID_PIXCNT_EN
  ,
  output logic [16:0] pix_count
`endif
);

  localparam int unsigned XW    = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int unsigned YW    = $clog2(V_RES + 1);
  localparam int unsigned SW    = 25;
  localparam int unsigned CW    = 17;
  localparam int unsigned STEPS = 25;
  localparam int unsigned STW   = 5;

  typedef enum logic [2:0] {
    ACCUM = 3'd0,
    CHECK = 3'd1,
    DIV_X = 3'd2,
    DIV_Y = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state, next_state;

  logic [XW-1:0]  x;
  logic [YW-1:0]  y;
  logic           vsync_r, vsync_rr;
  logic           vs_rise;
  logic           in_frame;
  logic           bright;
  logic [SW-1:0]  sum_x, sum_y;
  logic [CW-1:0]  cnt;
  logic [SW-1:0]  lat_sx, lat_sy;
  logic [CW-1:0]  lat_cnt;
  logic           too_few;

  logic [SW-1:0]  dvd, dvd_nxt;
  logic [CW-1:0]  rem, rem_nxt;
  logic [CW:0]    trial;
  logic           trial_ge;
  logic [STW-1:0] step;
  logic [CW-1:0]  qx;
  logic           last_step;

  logic           div_init_x;
  logic           div_run;
  logic           ld_miss;
  logic           ld_done;

  logic           unused_din;
  assign unused_din = ^din[11:0];

  assign vs_rise   = vsync_r & ~vsync_rr;
  assign in_frame  = (y < YW'(V_RES));
  assign bright    = (din[15:12] > BRIGHT_TH);
  assign too_few   = (lat_cnt < MIN_PIX);
  assign last_step = (step == STW'(STEPS - 1));

  // One restoring-division step: shift in the next dividend bit, subtract if it fits
  always_comb begin
    trial    = {rem, dvd[SW-1]};
    trial_ge = (trial >= {1'b0, lat_cnt});
    rem_nxt  = trial_ge ? CW'(trial - {1'b0, lat_cnt}) : trial[CW-1:0];
    dvd_nxt  = {dvd[SW-2:0], trial_ge};
  end

  // Two-stage vsync sampling for edge detection
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_r  <= 1'b0;
      vsync_rr <= 1'b0;
    end else begin
      vsync_r  <= vsync;
      vsync_rr <= vsync_r;
    end
  end

  // Pixel position counters; cleared during vsync, frozen once past the last line
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (vsync) begin
      x <= '0;
      y <= '0;
    end else if (we && in_frame) begin
      if (x == XW'(H_RES - 1)) begin
        x <= '0;
        y <= y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
    end
  end

  // Bright-pixel accumulators, snapshotted and cleared at frame end
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      sum_x   <= '0;
      sum_y   <= '0;
      cnt     <= '0;
      lat_sx  <= '0;
      lat_sy  <= '0;
      lat_cnt <= '0;
    end else if (state == ACCUM) begin
      if (vs_rise) begin
        lat_sx  <= sum_x;
        lat_sy  <= sum_y;
        lat_cnt <= cnt;
        sum_x   <= '0;
        sum_y   <= '0;
        cnt     <= '0;
      end else if (we && bright && in_frame) begin
        sum_x <= sum_x + SW'(x);
        sum_y <= sum_y + SW'(y);
        cnt   <= cnt + CW'(1);
      end
    end
  end

  // FSM state register
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= next_state;
  end

  // FSM next-state logic
  always_comb begin
    next_state = state;
    case (state)
      ACCUM:   if (vs_rise) next_state = CHECK;
      CHECK:   next_state = too_few ? ACCUM : DIV_X;
      DIV_X:   if (last_step) next_state = DIV_Y;
      DIV_Y:   if (last_step) next_state = DONE;
      DONE:    next_state = ACCUM;
      default: next_state = ACCUM;
    endcase
  end

  // FSM control outputs
  always_comb begin
    div_init_x = 1'b0;
    div_run    = 1'b0;
    ld_miss    = 1'b0;
    ld_done    = 1'b0;
    case (state)
      CHECK: begin
        ld_miss    = too_few;
        div_init_x = ~too_few;
      end
      DIV_X:   div_run = 1'b1;
      DIV_Y: begin
        div_run = 1'b1;
        ld_done = last_step;
      end
      default: ;
    endcase
  end

  // Shared divider: X quotient first, then Y reusing the same datapath
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      dvd  <= '0;
      rem  <= '0;
      step <= '0;
      qx   <= '0;
    end else if (div_init_x) begin
      dvd  <= lat_sx;
      rem  <= '0;
      step <= '0;
    end else if (div_run) begin
      if (last_step) begin
        step <= '0;
        if (state == DIV_X) begin
          qx  <= dvd_nxt[CW-1:0];
          dvd <= lat_sy;
          rem <= '0;
        end else begin
          dvd <= dvd_nxt;
          rem <= rem_nxt;
        end
      end else begin
        step <= step + STW'(1);
        dvd  <= dvd_nxt;
        rem  <= rem_nxt;
      end
    end
  end

  // Result registers; the valid result lands as the FSM enters DONE so the pulse is the DONE cycle
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      avg_X     <= '0;
      avg_Y     <= '0;
      disappear <= 1'b1;
      avg_valid <= 1'b0;
    end else begin
      avg_valid <= ld_miss | ld_done;
      if (ld_miss) begin
        disappear <= 1'b1;
      end else if (ld_done) begin
        avg_X     <= qx;
        avg_Y     <= dvd_nxt[CW-1:0];
        disappear <= 1'b0;
      end
    end
  end

`ifdef CENTROID_PIXCNT_EN
  // Bright-pixel count of the frame just reported
  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n)                  pix_count <= '0;
    else if (ld_miss || ld_done) pix_count <= lat_cnt;
  end
`endif

endmodule

// File: tb/tb_laser_centroid.sv
// Directed bench for laser_centroid: a table of frames with hand-computed
// centroids and latencies, plus sequences for the ignored-vsync and
// reset-during-divide cases. Frame height is reduced to keep runtime short.
module tb_laser_centroid;

  localparam int H = 320;
  localparam int V = 60;

  logic        pclk = 1'b0;
  logic        rst_n;
  logic        vsync;
  logic        we;
  logic [15:0] din;
  logic [16:0] avg_X;
  logic [16:0] avg_Y;
  logic        disappear;
  logic        avg_valid;
`ifdef CENTROID_PIXCNT_EN
  logic [16:0] pix_count;
`endif

  laser_centroid #(
    .H_RES(H),
    .V_RES(V)
  ) dut (
    .pclk      (pclk),
    .rst_n     (rst_n),
    .vsync     (vsync),
    .we        (we),
    .din       (din),
    .avg_X     (avg_X),
    .avg_Y     (avg_Y),
    .disappear (disappear),
    .avg_valid (avg_valid)
`ifdef CENTROID_PIXCNT_EN
    ,
    .pix_count (pix_count)
`endif
  );

  always #5 pclk = ~pclk;

  typedef struct {
    int mode;
    int npix;
    int lat;
    int ex;
    int ey;
    int dis;
  } vec_t;

  vec_t vecs [6];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // 0: 3x3 block at (100,50)  1: three pixels  2: four corners
  // 3: nothing bright         4: four pixels in row 2  5: everything
  function automatic bit bright_at(input int mode, input int px, input int py);
    case (mode)
      0: return (px >= 99 && px <= 101 && py >= 49 && py <= 51);
      1: return (py == 0 && px >= 5 && px <= 7);
      2: return ((px == 0 || px == H - 1) && (py == 0 || py == V - 1));
      4: return (py == 2 && px >= 10 && px <= 13);
      5: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Dark pixels use top nibbles 0..12, so 12 exercises the threshold boundary
  task automatic stream(input int mode, input int npix);
    int px, py;
    for (int i = 0; i < npix; i++) begin
      px = i % H;
      py = i / H;
      @(negedge pclk);
      we = 1'b1;
      if (bright_at(mode, px, py)) din = {4'hD, 12'($urandom)};
      else                         din = {4'($urandom_range(0, 12)), 12'($urandom)};
    end
    @(negedge pclk);
    we  = 1'b0;
    din = '0;
  endtask

  // Raise vsync, optionally inject a second pulse, and record the first result pulse
  task automatic close_frame(input bit inject, output int lat, output int pulses,
                             output int ax, output int ay, output int dis);
    lat = 0; pulses = 0; ax = -1; ay = -1; dis = -1;
    @(negedge pclk);
    vsync = 1'b1;
    for (int k = 1; k <= 80; k++) begin
      @(posedge pclk);
      #1;
      if (avg_valid) begin
        pulses++;
        if (lat == 0) begin
          lat = k;
          ax  = int'(avg_X);
          ay  = int'(avg_Y);
          dis = int'(disappear);
        end
      end
      if (k == 4) vsync = 1'b0;
      if (inject && k == 10) vsync = 1'b1;
      if (inject && k == 13) vsync = 1'b0;
    end
  endtask

  initial begin
    int lat, pulses, ax, ay, dis;
    string tag;

    vecs[0] = '{mode: 0, npix: 16640,   lat: 53, ex: 100, ey: 50, dis: 0};
    vecs[1] = '{mode: 1, npix: 20,      lat: 3,  ex: 100, ey: 50, dis: 1};
    vecs[2] = '{mode: 2, npix: H * V,   lat: 53, ex: 159, ey: 29, dis: 0};
    vecs[3] = '{mode: 3, npix: 0,       lat: 3,  ex: 159, ey: 29, dis: 1};
    vecs[4] = '{mode: 4, npix: 654,     lat: 53, ex: 11,  ey: 2,  dis: 0};
    vecs[5] = '{mode: 5, npix: H*V+40,  lat: 53, ex: 159, ey: 29, dis: 0};

    rst_n = 1'b0;
    vsync = 1'b0;
    we    = 1'b0;
    din   = '0;
    repeat (3) @(negedge pclk);
    check("reset avg_X", int'(avg_X), 0);
    check("reset avg_Y", int'(avg_Y), 0);
    check("reset disappear", int'(disappear), 1);
    check("reset avg_valid", int'(avg_valid), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge pclk);
    check("idle avg_valid", int'(avg_valid), 0);

    for (int i = 0; i < 6; i++) begin
      stream(vecs[i].mode, vecs[i].npix);
      close_frame(1'b0, lat, pulses, ax, ay, dis);
      tag = $sformatf("vec%0d", i);
      check({tag, " latency"}, lat, vecs[i].lat);
      check({tag, " pulses"}, pulses, 1);
      check({tag, " avg_X"}, ax, vecs[i].ex);
      check({tag, " avg_Y"}, ay, vecs[i].ey);
      check({tag, " disappear"}, dis, vecs[i].dis);
    end

    // Second vsync during the divide is ignored
    stream(4, 654);
    close_frame(1'b1, lat, pulses, ax, ay, dis);
    check("dbl_vsync latency", lat, 53);
    check("dbl_vsync pulses", pulses, 1);
    check("dbl_vsync avg_X", ax, 11);
    check("dbl_vsync avg_Y", ay, 2);
    check("dbl_vsync disappear", dis, 0);

    // Reset in the middle of DIV_X aborts the result
    stream(4, 654);
    @(negedge pclk);
    vsync = 1'b1;
    repeat (10) @(posedge pclk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_div avg_X", int'(avg_X), 0);
    check("rst_div avg_Y", int'(avg_Y), 0);
    check("rst_div disappear", int'(disappear), 1);
    check("rst_div avg_valid", int'(avg_valid), 0);
    vsync = 1'b0;
    repeat (2) @(negedge pclk);
    rst_n = 1'b1;
    pulses = 0;
    for (int k = 0; k < 80; k++) begin
      @(posedge pclk);
      #1;
      if (avg_valid) pulses++;
    end
    check("rst_div no pulse", pulses, 0);
    check("rst_div disappear held", int'(disappear), 1);

    stream(4, 654);
    close_frame(1'b0, lat, pulses, ax, ay, dis);
    check("post_rst latency", lat, 53);
    check("post_rst pulses", pulses, 1);
    check("post_rst avg_X", ax, 11);
    check("post_rst avg_Y", ay, 2);
    check("post_rst disappear", dis, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
